// File: rtl/seq_match_ctrl_if.sv
// Host-side control and serial-input bundle for the programmable sequence matcher.
// The host (or bench) takes the master view; the matcher takes the slave view.
interface seq_match_ctrl_if #(
   parameter int MAXLEN = 8,
   parameter int CNTW   = 8
);
   localparam int LENW = $clog2(MAXLEN) + 1;

   // configuration and sequencing requests
   logic              cfg_we;
   logic [MAXLEN-1:0] cfg_pattern;
   logic [LENW-1:0]   cfg_len;
   logic [CNTW-1:0]   cfg_target;
   logic              start;
   logic              abort;

   // serial input path
   logic              w_valid;
   logic              w;

   // status back to the host
   logic              z;
   logic              busy;
   logic              done;
   logic [CNTW-1:0]   hit_count;
   logic              cfg_err;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, w_valid, w,
      input  z, busy, done, hit_count, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, w_valid, w,
      output z, busy, done, hit_count, cfg_err
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern detector with arm/abort sequencing and a hit
// counter. The pattern is matched against a shift history of the accepted
// bits, overlapping matches count, and the block parks in DONE once the
// programmed number of hits is reached (target 0 means run until abort).
module seq_match_ctrl #(
   parameter int MAXLEN = 8,
   parameter int CNTW   = 8
) (
   input  logic              clk,
   input  logic              reset,
   seq_match_ctrl_if.slave   bus
);
   localparam int LENW = $clog2(MAXLEN) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit mask selecting the low len bits of the history/pattern.
   function automatic logic [MAXLEN-1:0] len_mask(input logic [LENW-1:0] len);
      logic [MAXLEN-1:0] m;
      for (int i = 0; i < MAXLEN; i++) begin
         m[i] = (i < int'(len));
      end
      return m;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // registered state
   state_t            r_state;
   logic [MAXLEN-1:0] r_pattern;
   logic [LENW-1:0]   r_len;
   logic [CNTW-1:0]   r_target;
   logic [MAXLEN-1:0] r_hist;
   logic [LENW-1:0]   r_seen;
   logic [CNTW-1:0]   r_hit;
   logic              r_z;
   logic              r_busy;
   logic              r_done;
   logic              r_cfg_err;

   // next-state values
   state_t            w_state_nxt;
   logic [MAXLEN-1:0] w_pattern_nxt;
   logic [LENW-1:0]   w_len_nxt;
   logic [CNTW-1:0]   w_target_nxt;
   logic [MAXLEN-1:0] w_hist_nxt;
   logic [LENW-1:0]   w_seen_nxt;
   logic [CNTW-1:0]   w_hit_nxt;
   logic              w_z_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_cfg_err_nxt;

   // datapath helpers
   logic [MAXLEN-1:0] w_hist_shift;
   logic [LENW:0]     w_seen_p1;
   logic [LENW-1:0]   w_seen_sat;
   logic [MAXLEN-1:0] w_mask;
   logic              w_len_ok;
   logic              w_match;
   logic              w_tgt_hit;

   // History as it would look after shifting in the current bit.
   assign w_hist_shift = {r_hist[MAXLEN-2:0], bus.w};

   // bits_seen is one wider here so the +1 cannot wrap before the compare.
   assign w_seen_p1  = {1'b0, r_seen} + (LENW+1)'(1);
   assign w_seen_sat = (w_seen_p1 >= (LENW+1)'(MAXLEN)) ? LENW'(MAXLEN)
                                                         : w_seen_p1[LENW-1:0];

   // A new length is usable only in 1..MAXLEN.
   assign w_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LENW'(MAXLEN));

   // Compare only the low len bits, and only once enough bits have arrived.
   assign w_mask  = len_mask(r_len);
   assign w_match = (w_seen_p1 >= {1'b0, r_len}) &&
                    (((w_hist_shift ^ r_pattern) & w_mask) == '0);

   // This hit would be the one that reaches a non-zero target.
   assign w_tgt_hit = (r_target != '0) &&
                      (({1'b0, r_hit} + (CNTW+1)'(1)) == {1'b0, r_target});

   // Next-state, configuration and output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_pattern_nxt = r_pattern;
      w_len_nxt     = r_len;
      w_target_nxt  = r_target;
      w_hist_nxt    = r_hist;
      w_seen_nxt    = r_seen;
      w_hit_nxt     = r_hit;
      w_z_nxt       = 1'b0;
      w_cfg_err_nxt = 1'b0;

      // Config writes land only while not armed; a bad length leaves the old
      // config in place. An accepted write also clears the stale hit count.
      if (bus.cfg_we) begin
         if ((r_state == ARMED) || !w_len_ok) begin
            w_cfg_err_nxt = 1'b1;
         end else begin
            w_pattern_nxt = bus.cfg_pattern;
            w_len_nxt     = bus.cfg_len;
            w_target_nxt  = bus.cfg_target;
            w_hit_nxt     = '0;
         end
      end

      case (r_state)
         IDLE, DONE: begin
            // abort outranks start, so a simultaneous pair does nothing here
            if (bus.start && !bus.abort) begin
               if (r_len != '0) begin
                  w_state_nxt = ARMED;
                  w_hist_nxt  = '0;
                  w_seen_nxt  = '0;
                  w_hit_nxt   = '0;
               end else begin
                  w_cfg_err_nxt = 1'b1;
               end
            end
         end
         ARMED: begin
            if (bus.abort) begin
               w_state_nxt = IDLE;
            end else if (bus.w_valid) begin
               w_hist_nxt = w_hist_shift;
               w_seen_nxt = w_seen_sat;
               if (w_match) begin
                  w_z_nxt   = 1'b1;
                  w_hit_nxt = sat_inc(r_hit);
                  if (w_tgt_hit) begin
                     w_state_nxt = DONE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == ARMED);
      w_done_nxt = (w_state_nxt == DONE);
   end

   // State, configuration, history and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pattern <= '0;
         r_len     <= '0;
         r_target  <= '0;
         r_hist    <= '0;
         r_seen    <= '0;
         r_hit     <= '0;
         r_z       <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pattern <= w_pattern_nxt;
         r_len     <= w_len_nxt;
         r_target  <= w_target_nxt;
         r_hist    <= w_hist_nxt;
         r_seen    <= w_seen_nxt;
         r_hit     <= w_hit_nxt;
         r_z       <= w_z_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_cfg_err <= w_cfg_err_nxt;
      end
   end

   assign bus.z         = r_z;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.hit_count = r_hit;
   assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: each task drives one scenario and checks
// the registered outputs one time unit after the clock edge that produced them.
`timescale 1ns/1ps
module tb_seq_match_ctrl;
   localparam int MAXLEN = 8;
   localparam int CNTW   = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seq_match_ctrl_if #(.MAXLEN(MAXLEN), .CNTW(CNTW)) bus ();

   seq_match_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
      bus.cfg_we      = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_target  = tgt;
      tick();
      bus.cfg_we      = 1'b0;
   endtask

   task automatic arm();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bus.w_valid = 1'b1;
      bus.w       = b;
      tick();
      bus.w_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if ({bus.z, bus.busy, bus.done, bus.cfg_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got z/busy/done/err=%b expected 0000",
                  {bus.z, bus.busy, bus.done, bus.cfg_err});
      end
      checks++;
      if (bus.hit_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_hit: got %0d expected 0", bus.hit_count);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({bus.z, bus.busy, bus.done, bus.cfg_err} !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_idle: got z/busy/done/err=%b expected 0000",
                  {bus.z, bus.busy, bus.done, bus.cfg_err});
      end
   endtask

   task automatic test_basic();
      logic [6:0] bits;
      bits = 7'b0110011;
      configure(8'b0110011, 4'd7, 8'd1);
      arm();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_armed: got %b expected 1", bus.busy);
      end
      for (int i = 0; i < 7; i++) begin
         send_bit(bits[6-i]);
         checks++;
         if (bus.z !== (i == 6)) begin
            errors++;
            $display("FAIL basic_z_bit%0d: got %b expected %b", i + 1, bus.z, (i == 6));
         end
      end
      checks++;
      if ({bus.hit_count, bus.done, bus.busy} !== {8'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL basic_final: got hit=%0d done=%b busy=%b expected hit=1 done=1 busy=0",
                  bus.hit_count, bus.done, bus.busy);
      end
      tick();
      checks++;
      if ({bus.z, bus.done, bus.busy} !== 3'b010) begin
         errors++;
         $display("FAIL basic_after: got z/done/busy=%b expected 010", {bus.z, bus.done, bus.busy});
      end
   endtask

   task automatic test_overlap();
      logic [4:0] bits;
      logic [4:0] expz;
      logic [7:0] exph [5];
      bits = 5'b10101;
      expz = 5'b00101;
      exph = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
      configure(8'b101, 4'd3, 8'd2);
      arm();
      for (int i = 0; i < 5; i++) begin
         send_bit(bits[4-i]);
         checks++;
         if ({bus.z, bus.hit_count} !== {expz[4-i], exph[i]}) begin
            errors++;
            $display("FAIL overlap_bit%0d: got z=%b hit=%0d expected z=%b hit=%0d",
                     i + 1, bus.z, bus.hit_count, expz[4-i], exph[i]);
         end
      end
      checks++;
      if ({bus.done, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL overlap_done: got done/busy=%b expected 10", {bus.done, bus.busy});
      end
   endtask

   task automatic test_gapped();
      logic [4:0] bits;
      logic [4:0] expz;
      bits = 5'b10101;
      expz = 5'b00101;
      configure(8'b101, 4'd3, 8'd2);
      arm();
      for (int i = 0; i < 5; i++) begin
         send_bit(bits[4-i]);
         checks++;
         if (bus.z !== expz[4-i]) begin
            errors++;
            $display("FAIL gapped_bit%0d: got z=%b expected %b", i + 1, bus.z, expz[4-i]);
         end
         bus.w = 1'b1;
         tick();
         checks++;
         if (bus.z !== 1'b0) begin
            errors++;
            $display("FAIL gapped_gap%0d: got z=%b expected 0", i + 1, bus.z);
         end
      end
      checks++;
      if ({bus.hit_count, bus.done} !== {8'd2, 1'b1}) begin
         errors++;
         $display("FAIL gapped_final: got hit=%0d done=%b expected hit=2 done=1",
                  bus.hit_count, bus.done);
      end
   endtask

   task automatic test_errors();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      configure(8'b11, 4'd0, 8'd0);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_len0: got cfg_err=%b expected 1", bus.cfg_err);
      end
      tick();
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_width: got cfg_err=%b expected 0", bus.cfg_err);
      end
      arm();
      checks++;
      if ({bus.cfg_err, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL err_start_unconfigured: got err/busy=%b expected 10", {bus.cfg_err, bus.busy});
      end
      configure(8'b11, 4'd9, 8'd0);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_len_too_big: got cfg_err=%b expected 1", bus.cfg_err);
      end
      configure(8'b11, 4'd2, 8'd0);
      arm();
      checks++;
      if ({bus.cfg_err, bus.busy} !== 2'b01) begin
         errors++;
         $display("FAIL err_valid_start: got err/busy=%b expected 01", {bus.cfg_err, bus.busy});
      end
      configure(8'b00, 4'd2, 8'd0);
      checks++;
      if ({bus.cfg_err, bus.busy} !== 2'b11) begin
         errors++;
         $display("FAIL err_cfg_armed: got err/busy=%b expected 11", {bus.cfg_err, bus.busy});
      end
      send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if (bus.z !== 1'b1) begin
         errors++;
         $display("FAIL err_old_pattern_kept: got z=%b expected 1", bus.z);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_abort();
      logic [2:0] expz;
      expz = 3'b011;
      configure(8'b11, 4'd2, 8'd0);
      arm();
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b1);
         checks++;
         if (bus.z !== expz[2-i]) begin
            errors++;
            $display("FAIL abort_stream_bit%0d: got z=%b expected %b", i + 1, bus.z, expz[2-i]);
         end
      end
      checks++;
      if (bus.hit_count !== 8'd2) begin
         errors++;
         $display("FAIL abort_hits: got %0d expected 2", bus.hit_count);
      end
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      bus.w_valid = 1'b1;
      bus.w       = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.w_valid = 1'b0;
      checks++;
      if ({bus.z, bus.busy, bus.done, bus.hit_count} !== {3'b000, 8'd2}) begin
         errors++;
         $display("FAIL abort_start_same_cycle: got z/busy/done=%b hit=%0d expected 000 hit=2",
                  {bus.z, bus.busy, bus.done}, bus.hit_count);
      end
      send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if ({bus.z, bus.busy, bus.hit_count} !== {2'b00, 8'd2}) begin
         errors++;
         $display("FAIL abort_ignores_w: got z/busy=%b hit=%0d expected 00 hit=2",
                  {bus.z, bus.busy}, bus.hit_count);
      end
   endtask

   task automatic test_saturate();
      arm();
      checks++;
      if ({bus.busy, bus.hit_count} !== {1'b1, 8'd0}) begin
         errors++;
         $display("FAIL sat_rearm: got busy=%b hit=%0d expected busy=1 hit=0", bus.busy, bus.hit_count);
      end
      for (int i = 0; i < 260; i++) begin
         send_bit(1'b1);
      end
      checks++;
      if ({bus.z, bus.busy, bus.hit_count} !== {2'b11, 8'd255}) begin
         errors++;
         $display("FAIL sat_hits: got z/busy=%b hit=%0d expected 11 hit=255",
                  {bus.z, bus.busy}, bus.hit_count);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [6:0] bits;
      bits = 7'b0110011;
      configure(8'b0110011, 4'd7, 8'd1);
      arm();
      for (int i = 0; i < 6; i++) begin
         send_bit(bits[6-i]);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.z, bus.busy, bus.done, bus.cfg_err, bus.hit_count} !== {4'b0000, 8'd0}) begin
         errors++;
         $display("FAIL async_reset_immediate: got z/busy/done/err=%b hit=%0d expected 0000 hit=0",
                  {bus.z, bus.busy, bus.done, bus.cfg_err}, bus.hit_count);
      end
      tick();
      reset = 1'b0;
      configure(8'b0110011, 4'd7, 8'd1);
      arm();
      send_bit(1'b1);
      checks++;
      if ({bus.z, bus.done, bus.busy} !== 3'b001) begin
         errors++;
         $display("FAIL async_no_stale_match: got z/done/busy=%b expected 001", {bus.z, bus.done, bus.busy});
      end
      for (int i = 0; i < 7; i++) begin
         send_bit(bits[6-i]);
      end
      checks++;
      if ({bus.z, bus.done, bus.hit_count} !== {2'b11, 8'd1}) begin
         errors++;
         $display("FAIL async_rematch: got z/done=%b hit=%0d expected 11 hit=1",
                  {bus.z, bus.done}, bus.hit_count);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_target  = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.w_valid     = 1'b0;
      bus.w           = 1'b0;

      test_reset();
      test_basic();
      test_overlap();
      test_gapped();
      test_errors();
      test_abort();
      test_saturate();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Controller that configures, arms and sequences a serial pattern detector on a bit stream `w`.
- Holds a runtime-loaded pattern of up to MAXLEN bits and matches it on the incoming stream. Overlapping matches are allowed.
- Counts matches and raises `done` when a programmed target count is reached.
- Sits between a host control interface (config, start/abort) and the serial input path, replacing hard-coded detector FSMs with one programmable block.

Parameters:
- MAXLEN, 8, maximum pattern length in bits; legal range 2..16.
- CNTW, 8, width of the target and hit counters.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  config write strobe, one cycle.
- cfg_pattern  input  MAXLEN  pattern bits; bit [cfg_len-1] is the oldest/first bit, bit [0] the newest/last.
- cfg_len  input  $clog2(MAXLEN)+1  pattern length; legal 1..MAXLEN.
- cfg_target  input  CNTW  hits required before `done`; 0 = unlimited.
- start  input  1  arm request, one-cycle pulse.
- abort  input  1  disarm request, one-cycle pulse.
- w_valid  input  1  `w` is sampled at the rising edge when this is 1.
- w  input  1  serial data bit.
- z  output  1  match pulse, one cycle per match.
- busy  output  1  high in ARMED.
- done  output  1  high in DONE.
- hit_count  output  CNTW  matches since the last start.
- cfg_err  output  1  one-cycle pulse on a rejected config or start.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - pattern = 0, len = 0 (unconfigured), target = 0
  - history = 0, bits_seen = 0, hit_count = 0
  - z = 0, busy = 0, done = 0, cfg_err = 0
- Reset asserted mid-operation aborts immediately. No match or `done` is reported afterwards.
- States: IDLE, ARMED, DONE. busy = (state == ARMED); done = (state == DONE). Both are registered.
- Config write (`cfg_we`) is accepted only in IDLE or DONE and takes effect at that edge.
  - If cfg_len == 0 or cfg_len > MAXLEN: config is unchanged and `cfg_err` pulses.
  - In ARMED: the write is ignored and `cfg_err` pulses.
- IDLE/DONE + start:
  - If len != 0: go to ARMED; clear history, bits_seen and hit_count.
  - If len == 0: stay in the current state and pulse `cfg_err`.
- ARMED + start: ignored; no error.
- ARMED + abort: go to IDLE; hit_count is retained; no `z` is issued that cycle.
- start and abort in the same cycle: abort wins (ARMED -> IDLE; IDLE/DONE stay put).
- Sampling in ARMED with w_valid = 1, at edge k:
  - history <= {history[MAXLEN-2:0], w}
  - bits_seen <= min(bits_seen + 1, MAXLEN)
- Match at edge k when (bits_seen + 1) >= len and the new history[len-1:0] == pattern[len-1:0]. On a match:
  - z = 1 for the single cycle after edge k.
  - hit_count increments, saturating at all-ones.
- History is not cleared on a match, so overlapping matches count.
- Target reached: if target != 0 and hit_count + 1 == target at edge k, the state goes to DONE at that same edge, together with the final `z`.
- target == 0: ARMED runs until abort; hit_count saturates.
- w_valid = 0: no shift, no match; z = 0 next cycle.
- DONE and IDLE ignore w_valid. DONE holds hit_count until the next start, config write or reset.
- hit_count and state update from the same edge (zero extra latency). `z`, `cfg_err` and `done` are register outputs.

Test Plan:
- Reset then configure pattern 7'b0110011, len 7, target 1, start. Feed 0,1,1,0,0,1,1 with w_valid = 1 every cycle -> z = 1 for exactly one cycle after the 7th bit; hit_count = 1; done = 1, busy = 0 from that cycle on.
- Overlap: pattern 3'b101, len 3, target 2. Stream 1,0,1,0,1 -> z after bits 3 and 5; hit_count = 2; done after bit 5.
- Gapped valid: same 101 config, with w_valid = 0 cycles inserted between every bit -> match timing follows valid samples only; no spurious z.
- Errors:
  - cfg_len = 0 -> cfg_err = 1, start then rejected with cfg_err = 1.
  - cfg_we while ARMED -> cfg_err = 1, pattern unchanged (verify by a subsequent match on the old pattern).
- Abort: target 0, pattern 2'b11. Stream 1,1,1 -> hit_count = 2. Then start + abort in the same cycle -> IDLE, busy = 0, hit_count = 2, and further w ignored.
- Async reset asserted between clock edges while ARMED with a partial match -> all outputs 0 immediately. After release and re-arm, the earlier partial history does not complete a match.
